// File: rtl/bfp_block_align.sv
// bfp_block_align: captures one block-floating-point block into a ping-pong
// buffer while tracking the block's maximum exponent, then replays it with
// every sample rounded (symmetric) down to that common exponent.
// Optional build macro: BFP_ALIGN_BITREV_EN -- when defined the replay address
// is bit-reversed over the low ldn bits (natural frequency order out).
module bfp_block_align #(
  parameter int MAN_W  = 16,
  parameter int EXP_W  = 6,
  parameter int ADDR_W = 11
) (
  input  logic             clk_sys,
  input  logic             rst_sys,
  input  logic             block_sync_i,
  input  logic             data_val_i,
  input  logic [MAN_W-1:0] data_real_i,
  input  logic [MAN_W-1:0] data_imag_i,
  input  logic [EXP_W-1:0] data_exp_i,
  input  logic [3:0]       ldn_rg_i,
  output logic             block_sync_o,
  output logic             data_val_o,
  output logic [MAN_W-1:0] data_real_o,
  output logic [MAN_W-1:0] data_imag_o,
  output logic [EXP_W-1:0] blk_exp_o,
  output logic             overflow_o,
  output logic             abort_o
);

  localparam int             MEM_W   = 2 * MAN_W + EXP_W;
  localparam int             DEPTH   = 2 << ADDR_W;
  localparam logic [3:0]     LDN_MIN = 4'd6;
  localparam logic [3:0]     LDN_MAX = 4'(ADDR_W);
  localparam logic [EXP_W:0] SH_LIM  = (EXP_W + 1)'(MAN_W);

  typedef enum logic {W_IDLE = 1'b0, W_FILL = 1'b1} w_state_t;
  typedef enum logic {R_IDLE = 1'b0, R_DRAIN = 1'b1} r_state_t;

  // Last valid address of a block of length 1<<ldn.
  function automatic logic [ADDR_W-1:0] last_addr_f(input logic [3:0] ldn);
    return ~({ADDR_W{1'b1}} << ldn);
  endfunction

  // Two's-complement maximum of two exponents.
  function automatic logic [EXP_W-1:0] smax_f(input logic [EXP_W-1:0] a,
                                              input logic [EXP_W-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  // Symmetric-round right shift of a two's-complement mantissa by sh.
  function automatic logic [MAN_W-1:0] align_f(input logic [MAN_W-1:0] x,
                                               input logic [EXP_W:0]   sh);
    logic [MAN_W+1:0] one_v;
    logic [MAN_W+1:0] ax_v;
    logic [MAN_W+1:0] sum_v;
    logic [MAN_W-1:0] mag_v;
    logic [MAN_W-1:0] res_v;
    one_v = {{(MAN_W + 1){1'b0}}, 1'b1};
    ax_v  = x[MAN_W-1] ? ({2'b00, ~x} + one_v) : {2'b00, x};
    sum_v = (ax_v + (one_v << (sh - {{EXP_W{1'b0}}, 1'b1}))) >> sh;
    mag_v = MAN_W'(sum_v);
    if (sh == {(EXP_W + 1){1'b0}}) begin
      res_v = x;
    end else if (sh >= SH_LIM) begin
      res_v = {MAN_W{1'b0}};
    end else begin
      res_v = x[MAN_W-1] ? (~mag_v + {{(MAN_W - 1){1'b0}}, 1'b1}) : mag_v;
    end
    return res_v;
  endfunction

`ifdef BFP_ALIGN_BITREV_EN
  // Reverse the low ldn bits of an address (upper bits are zero by range).
  function automatic logic [ADDR_W-1:0] bitrev_f(input logic [ADDR_W-1:0] a,
                                                 input logic [3:0]        ldn);
    logic [ADDR_W-1:0] r_v;
    for (int i = 0; i < ADDR_W; i++) begin
      r_v[i] = a[ADDR_W-1-i];
    end
    return r_v >> (LDN_MAX - ldn);
  endfunction
`endif

  logic [MEM_W-1:0]  mem_r [0:DEPTH-1];

  w_state_t          w_state_r, w_state_s;
  logic [ADDR_W-1:0] wcnt_r, wcnt_s;
  logic [EXP_W-1:0]  max_exp_r, max_exp_s, mx_s;
  logic              wsel_r, wsel_s;
  logic [3:0]        ldn_r, ldn_s, ldn_clamp_s;
  logic              wr_en_s;
  logic [ADDR_W-1:0] wr_addr_s;
  logic              sync_val_s, bank_free_s, w_done_s;
  logic              abort_set_s, ovf_set_s;

  logic [1:0]        full_r;
  logic [EXP_W-1:0]  bank_exp_r [0:1];
  logic [3:0]        bank_ldn_r [0:1];

  r_state_t          r_state_r, r_state_s;
  logic [ADDR_W-1:0] raddr_r, raddr_s, rd_phys_s;
  logic              rsel_r, rsel_s, free_s;

  logic              rd_val_r, rd_first_r;
  logic [EXP_W-1:0]  rd_bexp_r;
  logic [MEM_W-1:0]  rd_q_r;
  logic [EXP_W:0]    sh_s;

  assign sync_val_s  = block_sync_i & data_val_i;
  assign ldn_clamp_s = ((ldn_rg_i < LDN_MIN) || (ldn_rg_i > LDN_MAX)) ? LDN_MAX : ldn_rg_i;
  assign mx_s        = smax_f(max_exp_r, data_exp_i);
  assign free_s      = (r_state_r == R_DRAIN) && (raddr_r == last_addr_f(bank_ldn_r[rsel_r]));
  assign w_done_s    = (w_state_r == W_FILL) && data_val_i && !block_sync_i &&
                       (wcnt_r == last_addr_f(ldn_r));
  // A bank whose last read issues this cycle may take the next block's first write.
  assign bank_free_s = !full_r[wsel_r] || (free_s && (rsel_r == wsel_r));

`ifdef BFP_ALIGN_BITREV_EN
  assign rd_phys_s = bitrev_f(raddr_r, bank_ldn_r[rsel_r]);
`else
  assign rd_phys_s = raddr_r;
`endif

  // Write FSM next state: start, fill, restart on early sync, complete a bank.
  always_comb begin
    w_state_s   = w_state_r;
    wcnt_s      = wcnt_r;
    max_exp_s   = max_exp_r;
    wsel_s      = wsel_r;
    ldn_s       = ldn_r;
    wr_en_s     = 1'b0;
    wr_addr_s   = wcnt_r;
    abort_set_s = 1'b0;
    ovf_set_s   = 1'b0;
    case (w_state_r)
      W_IDLE: begin
        if (sync_val_s && bank_free_s) begin
          wr_en_s   = 1'b1;
          wr_addr_s = {ADDR_W{1'b0}};
          max_exp_s = data_exp_i;
          wcnt_s    = {{(ADDR_W - 1){1'b0}}, 1'b1};
          ldn_s     = ldn_clamp_s;
          w_state_s = W_FILL;
        end else if (sync_val_s) begin
          ovf_set_s = 1'b1;
        end else begin
          w_state_s = W_IDLE;
        end
      end
      W_FILL: begin
        if (sync_val_s) begin
          abort_set_s = 1'b1;
          wr_en_s     = 1'b1;
          wr_addr_s   = {ADDR_W{1'b0}};
          max_exp_s   = data_exp_i;
          wcnt_s      = {{(ADDR_W - 1){1'b0}}, 1'b1};
          ldn_s       = ldn_clamp_s;
        end else if (data_val_i) begin
          wr_en_s   = 1'b1;
          max_exp_s = mx_s;
          if (w_done_s) begin
            wsel_s    = ~wsel_r;
            w_state_s = W_IDLE;
          end else begin
            wcnt_s = wcnt_r + {{(ADDR_W - 1){1'b0}}, 1'b1};
          end
        end else begin
          w_state_s = W_FILL;
        end
      end
      default: w_state_s = W_IDLE;
    endcase
  end

  // Write FSM state registers.
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      w_state_r <= W_IDLE;
      wcnt_r    <= {ADDR_W{1'b0}};
      max_exp_r <= {EXP_W{1'b0}};
      wsel_r    <= 1'b0;
      ldn_r     <= LDN_MAX;
    end else begin
      w_state_r <= w_state_s;
      wcnt_r    <= wcnt_s;
      max_exp_r <= max_exp_s;
      wsel_r    <= wsel_s;
      ldn_r     <= ldn_s;
    end
  end

  // Sample store: one write port (current fill bank) and one registered read.
  always_ff @(posedge clk_sys) begin
    if (wr_en_s) begin
      mem_r[{wsel_r, wr_addr_s}] <= {data_real_i, data_imag_i, data_exp_i};
    end
    rd_q_r <= mem_r[{rsel_r, rd_phys_s}];
  end

  // Bank bookkeeping: set on fill completion, clear after the last read.
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      full_r <= 2'b00;
      for (int b = 0; b < 2; b++) begin
        bank_exp_r[b] <= {EXP_W{1'b0}};
        bank_ldn_r[b] <= LDN_MAX;
      end
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (w_done_s && (wsel_r == 1'(b))) begin
          full_r[b]     <= 1'b1;
          bank_exp_r[b] <= mx_s;
          bank_ldn_r[b] <= ldn_r;
        end else if (free_s && (rsel_r == 1'(b))) begin
          full_r[b] <= 1'b0;
        end
      end
    end
  end

  // Read FSM next state: gapless drain, chaining straight into a ready bank.
  always_comb begin
    r_state_s = r_state_r;
    raddr_s   = raddr_r;
    rsel_s    = rsel_r;
    case (r_state_r)
      R_IDLE: begin
        if (full_r[rsel_r]) begin
          r_state_s = R_DRAIN;
          raddr_s   = {ADDR_W{1'b0}};
        end else begin
          r_state_s = R_IDLE;
        end
      end
      R_DRAIN: begin
        if (free_s) begin
          raddr_s = {ADDR_W{1'b0}};
          rsel_s  = ~rsel_r;
          if (full_r[~rsel_r] || (w_done_s && (wsel_r != rsel_r))) begin
            r_state_s = R_DRAIN;
          end else begin
            r_state_s = R_IDLE;
          end
        end else begin
          raddr_s = raddr_r + {{(ADDR_W - 1){1'b0}}, 1'b1};
        end
      end
      default: r_state_s = R_IDLE;
    endcase
  end

  // Read FSM state registers.
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      r_state_r <= R_IDLE;
      raddr_r   <= {ADDR_W{1'b0}};
      rsel_r    <= 1'b0;
    end else begin
      r_state_r <= r_state_s;
      raddr_r   <= raddr_s;
      rsel_r    <= rsel_s;
    end
  end

  // Control that travels alongside the registered memory read.
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      rd_val_r   <= 1'b0;
      rd_first_r <= 1'b0;
      rd_bexp_r  <= {EXP_W{1'b0}};
    end else begin
      rd_val_r   <= (r_state_r == R_DRAIN);
      rd_first_r <= (r_state_r == R_DRAIN) && (raddr_r == {ADDR_W{1'b0}});
      rd_bexp_r  <= bank_exp_r[rsel_r];
    end
  end

  assign sh_s = {rd_bexp_r[EXP_W-1], rd_bexp_r} -
                {rd_q_r[EXP_W-1], rd_q_r[EXP_W-1:0]};

  // Align stage: rounded shift to the block exponent, zeros between samples.
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      data_val_o   <= 1'b0;
      block_sync_o <= 1'b0;
      data_real_o  <= {MAN_W{1'b0}};
      data_imag_o  <= {MAN_W{1'b0}};
      blk_exp_o    <= {EXP_W{1'b0}};
    end else if (rd_val_r) begin
      data_val_o   <= 1'b1;
      block_sync_o <= rd_first_r;
      data_real_o  <= align_f(rd_q_r[MEM_W-1 -: MAN_W], sh_s);
      data_imag_o  <= align_f(rd_q_r[EXP_W +: MAN_W], sh_s);
      blk_exp_o    <= rd_bexp_r;
    end else begin
      data_val_o   <= 1'b0;
      block_sync_o <= 1'b0;
      data_real_o  <= {MAN_W{1'b0}};
      data_imag_o  <= {MAN_W{1'b0}};
      blk_exp_o    <= {EXP_W{1'b0}};
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      overflow_o <= 1'b0;
      abort_o    <= 1'b0;
    end else begin
      overflow_o <= overflow_o | ovf_set_s;
      abort_o    <= abort_o | abort_set_s;
    end
  end

endmodule

// File: tb/tb_bfp_block_align.sv
// Directed self-checking bench for bfp_block_align.
module tb_bfp_block_align;

  logic        clk_sys = 1'b0;
  logic        rst_sys;
  logic        block_sync_i, data_val_i;
  logic [15:0] data_real_i, data_imag_i;
  logic [5:0]  data_exp_i;
  logic [3:0]  ldn_rg_i;
  logic        block_sync_o, data_val_o, overflow_o, abort_o;
  logic [15:0] data_real_o, data_imag_o;
  logic [5:0]  blk_exp_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_in_cyc = 0;

  logic signed [15:0] re_a [0:2047];
  logic signed [15:0] im_a [0:2047];
  logic signed [5:0]  ex_a [0:2047];

  logic               q_sync [$];
  logic signed [15:0] q_re [$];
  logic signed [15:0] q_im [$];
  logic signed [5:0]  q_ex [$];
  int                 q_cyc [$];

  bfp_block_align dut (
    .clk_sys(clk_sys), .rst_sys(rst_sys),
    .block_sync_i(block_sync_i), .data_val_i(data_val_i),
    .data_real_i(data_real_i), .data_imag_i(data_imag_i),
    .data_exp_i(data_exp_i), .ldn_rg_i(ldn_rg_i),
    .block_sync_o(block_sync_o), .data_val_o(data_val_o),
    .data_real_o(data_real_o), .data_imag_o(data_imag_o),
    .blk_exp_o(blk_exp_o), .overflow_o(overflow_o), .abort_o(abort_o)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cyc <= cyc + 1;

  always @(negedge clk_sys) begin
    if (data_val_o === 1'b1) begin
      q_sync.push_back(block_sync_o);
      q_re.push_back(data_real_o);
      q_im.push_back(data_imag_o);
      q_ex.push_back(blk_exp_o);
      q_cyc.push_back(cyc);
    end
  end

  function automatic int idx_of(input int i, input int ldn);
    int r;
    r = i & ((1 << ldn) - 1);
`ifdef BFP_ALIGN_BITREV_EN
    r = 0;
    for (int b = 0; b < ldn; b++) begin
      if (i[b]) r = r | (1 << (ldn - 1 - b));
    end
`endif
    return r;
  endfunction

  task automatic clear_q();
    q_sync.delete(); q_re.delete(); q_im.delete(); q_ex.delete(); q_cyc.delete();
  endtask

  task automatic idle_in(input int n);
    repeat (n) begin
      @(negedge clk_sys);
      block_sync_i = 1'b0; data_val_i = 1'b0;
      data_real_i = 16'd0; data_imag_i = 16'd0; data_exp_i = 6'd0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    rst_sys = 1'b1;
    idle_in(3);
    rst_sys = 1'b0;
    clear_q();
  endtask

  task automatic send_block(input int n, input logic [3:0] ldn);
    for (int k = 0; k < n; k++) begin
      @(negedge clk_sys);
      block_sync_i = (k == 0);
      data_val_i   = 1'b1;
      data_real_i  = re_a[k];
      data_imag_i  = im_a[k];
      data_exp_i   = ex_a[k];
      ldn_rg_i     = ldn;
    end
    last_in_cyc = cyc;
  endtask

  task automatic wait_out(input int n, input int budget);
    int t = 0;
    while (q_re.size() < n && t < budget) begin
      @(negedge clk_sys);
      t++;
    end
    repeat (20) @(negedge clk_sys);
  endtask

  task automatic test_reset();
    @(negedge clk_sys);
    rst_sys = 1'b1; block_sync_i = 1'b1; data_val_i = 1'b1;
    data_real_i = 16'h1234; data_imag_i = 16'h4321; data_exp_i = 6'd7; ldn_rg_i = 4'd6;
    repeat (3) @(negedge clk_sys);
    checks++; if (data_val_o !== 1'b0) begin failures++; $display("FAIL rst_val got %b want 0", data_val_o); end
    checks++; if (block_sync_o !== 1'b0) begin failures++; $display("FAIL rst_sync got %b want 0", block_sync_o); end
    checks++; if (data_real_o !== 16'd0) begin failures++; $display("FAIL rst_re got %0d want 0", data_real_o); end
    checks++; if (data_imag_o !== 16'd0) begin failures++; $display("FAIL rst_im got %0d want 0", data_imag_o); end
    checks++; if (blk_exp_o !== 6'd0) begin failures++; $display("FAIL rst_exp got %0d want 0", blk_exp_o); end
    checks++; if (overflow_o !== 1'b0) begin failures++; $display("FAIL rst_ovf got %b want 0", overflow_o); end
    checks++; if (abort_o !== 1'b0) begin failures++; $display("FAIL rst_abort got %b want 0", abort_o); end
    idle_in(1);
    rst_sys = 1'b0;
    clear_q();
  endtask

  task automatic test_passthrough();
    logic signed [15:0] er, ei;
    do_reset();
    for (int k = 0; k < 64; k++) begin
      re_a[k] = 16'(k); im_a[k] = 16'(-k); ex_a[k] = 6'sd3;
    end
    send_block(64, 4'd6);
    idle_in(1);
    wait_out(64, 300);
    checks++; if (q_re.size() != 64) begin failures++; $display("FAIL pass_count got %0d want 64", q_re.size()); end
    for (int i = 0; i < 64 && i < q_re.size(); i++) begin
      er = 16'(idx_of(i, 6)); ei = 16'(-idx_of(i, 6));
      checks++; if (q_re[i] !== er) begin failures++; $display("FAIL pass_re[%0d] got %0d want %0d", i, q_re[i], er); end
      checks++; if (q_im[i] !== ei) begin failures++; $display("FAIL pass_im[%0d] got %0d want %0d", i, q_im[i], ei); end
      checks++; if (q_ex[i] !== 6'sd3) begin failures++; $display("FAIL pass_exp[%0d] got %0d want 3", i, q_ex[i]); end
      checks++; if (q_sync[i] !== (i == 0)) begin failures++; $display("FAIL pass_sync[%0d] got %b want %b", i, q_sync[i], (i == 0)); end
    end
    if (q_cyc.size() == 64) begin
      checks++; if (q_cyc[0] - last_in_cyc < 3) begin failures++; $display("FAIL pass_latency got %0d want >=3", q_cyc[0] - last_in_cyc); end
      checks++; if (q_cyc[63] - q_cyc[0] != 63) begin failures++; $display("FAIL pass_contig got %0d want 63", q_cyc[63] - q_cyc[0]); end
    end
  endtask

  task automatic test_align_round();
    logic signed [15:0] er, ei;
    int s;
    do_reset();
    for (int k = 0; k < 64; k++) begin
      re_a[k] = 16'sd1000; im_a[k] = 16'sd6; ex_a[k] = 6'sd3;
    end
    ex_a[5] = 6'sd5;
    re_a[10] = -16'sd3;
    re_a[11] = 16'sd2;
    re_a[12] = 16'sh8000; im_a[12] = 16'sd0; ex_a[12] = 6'sd5;
    im_a[13] = -16'sd6;
    re_a[14] = -16'sd1000;
    re_a[15] = 16'sd5;
    re_a[16] = 16'sd6;
    re_a[17] = -16'sd6;
    send_block(64, 4'd6);
    idle_in(1);
    wait_out(64, 300);
    checks++; if (q_re.size() != 64) begin failures++; $display("FAIL round_count got %0d want 64", q_re.size()); end
    for (int i = 0; i < 64 && i < q_re.size(); i++) begin
      s = idx_of(i, 6);
      er = 16'sd250; ei = 16'sd2;
      case (s)
        5:       begin er = 16'sd1000; ei = 16'sd6; end
        10:      er = -16'sd1;
        11:      er = 16'sd1;
        12:      begin er = 16'sh8000; ei = 16'sd0; end
        13:      ei = -16'sd2;
        14:      er = -16'sd250;
        15:      er = 16'sd1;
        16:      er = 16'sd2;
        17:      er = -16'sd2;
        default: er = 16'sd250;
      endcase
      checks++; if (q_re[i] !== er) begin failures++; $display("FAIL round_re[%0d] got %0d want %0d", s, q_re[i], er); end
      checks++; if (q_im[i] !== ei) begin failures++; $display("FAIL round_im[%0d] got %0d want %0d", s, q_im[i], ei); end
      checks++; if (q_ex[i] !== 6'sd5) begin failures++; $display("FAIL round_exp[%0d] got %0d want 5", s, q_ex[i]); end
    end
  endtask

  task automatic test_align_boundary();
    logic signed [15:0] er, ei;
    int s;
    do_reset();
    for (int k = 0; k < 64; k++) begin
      re_a[k] = 16'(k * 100); im_a[k] = 16'(-k); ex_a[k] = 6'sd20;
    end
    re_a[1] = 16'sd32767; ex_a[1] = 6'sd4;
    re_a[2] = 16'sh8000;
    re_a[3] = 16'sd32767; ex_a[3] = 6'sd5;
    re_a[4] = 16'sd100; im_a[4] = 16'sd100; ex_a[4] = -6'sd12;
    re_a[5] = 16'sh8000; ex_a[5] = 6'sd19;
    re_a[6] = 16'sd1; ex_a[6] = 6'sh20;
    send_block(64, 4'd6);
    idle_in(1);
    wait_out(64, 300);
    checks++; if (q_re.size() != 64) begin failures++; $display("FAIL bound_count got %0d want 64", q_re.size()); end
    for (int i = 0; i < 64 && i < q_re.size(); i++) begin
      s = idx_of(i, 6);
      er = 16'(s * 100); ei = 16'(-s);
      case (s)
        1:       begin er = 16'sd0; ei = 16'sd0; end
        2:       er = 16'sh8000;
        3:       begin er = 16'sd1; ei = 16'sd0; end
        4:       begin er = 16'sd0; ei = 16'sd0; end
        5:       begin er = -16'sd16384; ei = -16'sd3; end
        6:       begin er = 16'sd0; ei = 16'sd0; end
        default: ei = 16'(-s);
      endcase
      checks++; if (q_re[i] !== er) begin failures++; $display("FAIL bound_re[%0d] got %0d want %0d", s, q_re[i], er); end
      checks++; if (q_im[i] !== ei) begin failures++; $display("FAIL bound_im[%0d] got %0d want %0d", s, q_im[i], ei); end
      checks++; if (q_ex[i] !== 6'sd20) begin failures++; $display("FAIL bound_exp[%0d] got %0d want 20", s, q_ex[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic signed [15:0] er;
    do_reset();
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < 256; k++) begin
        re_a[k] = 16'(b * 1000 + k); im_a[k] = 16'(b); ex_a[k] = 6'sd0;
      end
      send_block(256, 4'd8);
    end
    idle_in(1);
    wait_out(768, 1500);
    checks++; if (q_re.size() != 768) begin failures++; $display("FAIL b2b_count got %0d want 768", q_re.size()); end
    checks++; if (overflow_o !== 1'b0) begin failures++; $display("FAIL b2b_ovf got %b want 0", overflow_o); end
    checks++; if (abort_o !== 1'b0) begin failures++; $display("FAIL b2b_abort got %b want 0", abort_o); end
    if (q_cyc.size() == 768) begin
      checks++; if (q_cyc[767] - q_cyc[0] != 767) begin failures++; $display("FAIL b2b_contig got %0d want 767", q_cyc[767] - q_cyc[0]); end
    end
    for (int i = 0; i < 768 && i < q_re.size(); i++) begin
      er = 16'((i / 256) * 1000 + idx_of(i % 256, 8));
      checks++; if (q_re[i] !== er) begin failures++; $display("FAIL b2b_re[%0d] got %0d want %0d", i, q_re[i], er); end
      checks++; if (q_sync[i] !== (i % 256 == 0)) begin failures++; $display("FAIL b2b_sync[%0d] got %b want %b", i, q_sync[i], (i % 256 == 0)); end
    end
  endtask

  task automatic test_abort();
    logic signed [15:0] er;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_sys);
      block_sync_i = 1'b0; data_val_i = 1'b1; data_real_i = 16'd7777; data_exp_i = 6'd9;
    end
    for (int k = 0; k < 64; k++) begin
      re_a[k] = 16'(1000 + k); im_a[k] = 16'sd0; ex_a[k] = 6'sd1;
    end
    send_block(30, 4'd6);
    for (int k = 0; k < 64; k++) begin
      re_a[k] = 16'(k); im_a[k] = 16'(k); ex_a[k] = 6'sd2;
    end
    send_block(64, 4'd6);
    idle_in(1);
    wait_out(64, 400);
    checks++; if (abort_o !== 1'b1) begin failures++; $display("FAIL abort_flag got %b want 1", abort_o); end
    checks++; if (overflow_o !== 1'b0) begin failures++; $display("FAIL abort_ovf got %b want 0", overflow_o); end
    checks++; if (q_re.size() != 64) begin failures++; $display("FAIL abort_count got %0d want 64", q_re.size()); end
    for (int i = 0; i < 64 && i < q_re.size(); i++) begin
      er = 16'(idx_of(i, 6));
      checks++; if (q_re[i] !== er) begin failures++; $display("FAIL abort_re[%0d] got %0d want %0d", i, q_re[i], er); end
      checks++; if (q_ex[i] !== 6'sd2) begin failures++; $display("FAIL abort_exp[%0d] got %0d want 2", i, q_ex[i]); end
    end
  endtask

  task automatic test_overflow();
    logic signed [15:0] er;
    do_reset();
    for (int k = 0; k < 2048; k++) begin
      re_a[k] = 16'(k); im_a[k] = 16'sd0; ex_a[k] = 6'sd0;
    end
    send_block(2048, 4'd11);
    for (int k = 0; k < 64; k++) re_a[k] = 16'(5000 + k);
    send_block(64, 4'd6);
    idle_in(2);
    checks++; if (overflow_o !== 1'b0) begin failures++; $display("FAIL ovf_early got %b want 0", overflow_o); end
    for (int k = 0; k < 64; k++) re_a[k] = 16'(9000 + k);
    send_block(64, 4'd6);
    idle_in(2);
    checks++; if (overflow_o !== 1'b1) begin failures++; $display("FAIL ovf_flag got %b want 1", overflow_o); end
    wait_out(2112, 5000);
    checks++; if (q_re.size() != 2112) begin failures++; $display("FAIL ovf_count got %0d want 2112", q_re.size()); end
    if (q_re.size() >= 2112) begin
      er = 16'(idx_of(1, 11));
      checks++; if (q_re[1] !== er) begin failures++; $display("FAIL ovf_first_re got %0d want %0d", q_re[1], er); end
      checks++; if (q_sync[2048] !== 1'b1) begin failures++; $display("FAIL ovf_sync2 got %b want 1", q_sync[2048]); end
      for (int i = 0; i < 64; i++) begin
        er = 16'(5000 + idx_of(i, 6));
        checks++; if (q_re[2048 + i] !== er) begin failures++; $display("FAIL ovf_re[%0d] got %0d want %0d", i, q_re[2048 + i], er); end
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    logic signed [15:0] er, ei;
    int t = 0;
    do_reset();
    for (int k = 0; k < 256; k++) begin
      re_a[k] = 16'(k); im_a[k] = 16'sd0; ex_a[k] = 6'sd0;
    end
    send_block(10, 4'd8);
    send_block(256, 4'd8);
    idle_in(1);
    while (q_re.size() < 20 && t < 500) begin
      @(negedge clk_sys);
      t++;
    end
    checks++; if (q_re.size() < 20) begin failures++; $display("FAIL mid_drain_started got %0d want >=20", q_re.size()); end
    checks++; if (abort_o !== 1'b1) begin failures++; $display("FAIL mid_abort_pre got %b want 1", abort_o); end
    rst_sys = 1'b1;
    @(posedge clk_sys);
    #1;
    checks++; if (data_val_o !== 1'b0) begin failures++; $display("FAIL mid_rst_val got %b want 0", data_val_o); end
    checks++; if (data_real_o !== 16'd0) begin failures++; $display("FAIL mid_rst_re got %0d want 0", data_real_o); end
    checks++; if (abort_o !== 1'b0) begin failures++; $display("FAIL mid_rst_abort got %b want 0", abort_o); end
    checks++; if (overflow_o !== 1'b0) begin failures++; $display("FAIL mid_rst_ovf got %b want 0", overflow_o); end
    @(negedge clk_sys);
    rst_sys = 1'b0;
    clear_q();
    for (int k = 0; k < 64; k++) begin
      re_a[k] = 16'(300 + k); im_a[k] = 16'(-k); ex_a[k] = -6'sd2;
    end
    send_block(64, 4'd6);
    idle_in(1);
    wait_out(64, 300);
    checks++; if (q_re.size() != 64) begin failures++; $display("FAIL post_count got %0d want 64", q_re.size()); end
    for (int i = 0; i < 64 && i < q_re.size(); i++) begin
      er = 16'(300 + idx_of(i, 6)); ei = 16'(-idx_of(i, 6));
      checks++; if (q_re[i] !== er) begin failures++; $display("FAIL post_re[%0d] got %0d want %0d", i, q_re[i], er); end
      checks++; if (q_im[i] !== ei) begin failures++; $display("FAIL post_im[%0d] got %0d want %0d", i, q_im[i], ei); end
      checks++; if (q_ex[i] !== -6'sd2) begin failures++; $display("FAIL post_exp[%0d] got %0d want -2", i, q_ex[i]); end
    end
  endtask

  initial begin
    rst_sys = 1'b1; block_sync_i = 1'b0; data_val_i = 1'b0;
    data_real_i = 16'd0; data_imag_i = 16'd0; data_exp_i = 6'd0; ldn_rg_i = 4'd6;
    test_reset();
    test_passthrough();
    test_align_round();
    test_align_boundary();
    test_back_to_back();
    test_abort();
    test_overflow();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
